mc_cpu: RTL and testbench
=========================

Name: mc_cpu

Overview:
Multi-cycle MIPS-subset core, the successor to the single-cycle cpu. It shares one ALU across all steps and talks to a unified instruction/data memory over a req/ready handshake, so memory of any latency is supported. It adds reset, a parametrised reset vector and address width, an illegal-opcode trap, and writeback debug ports for the bench.

Parameters:
ADDR_W, 32, width of the PC and of mem_addr. Addresses are word addresses.
RESET_PC, 0, PC value loaded on reset.
NREG, 32, number of architectural registers. Must be a power of two, at most 32.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  asynchronous, active-low reset.
mem_req  out  1  memory request; held high until accepted.
mem_we  out  1  1 = write, 0 = read; valid while mem_req is high.
mem_addr  out  ADDR_W  word address.
mem_wdata  out  32  store data.
mem_rdata  in  32  read data; valid in the cycle mem_ready is high.
mem_ready  in  1  completes the current request.
halted  out  1  core stopped on an illegal opcode.
dbg_wb_en  out  1  one-cycle pulse on each register-file write.
dbg_wb_reg  out  5  register being written.
dbg_wb_data  out  32  value being written.
dbg_pc  out  ADDR_W  PC of the instruction in flight.

Behaviour:
- Reset (async assert, sync deassert handled by the top level):
  - PC = RESET_PC, state = FETCH, IR = 0, all registers = 0.
  - mem_req = 0, halted = 0, dbg_wb_en = 0.
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP.
- FETCH:
  - mem_req = 1, mem_we = 0, mem_addr = PC.
  - Stay in FETCH until mem_ready. On ready: IR <= mem_rdata, PC <= PC + 1 (wraps modulo 2^ADDR_W), go to DECODE.
- DECODE: latch A = rs and B = rt. Compute branch target = PC + sign-extended imm16, truncated to ADDR_W. Unknown opcode or funct -> TRAP.
- EXEC:
  - R-type (funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt) -> ALUOut, then WB.
  - addi (0x08) -> ALUOut = A + sext(imm), then WB.
  - lw (0x23) / sw (0x2B) -> ALUOut = A + sext(imm), then MEM.
  - beq (0x04) / bne (0x05): if taken, PC <= target. Then FETCH.
  - j (0x02): PC <= {PC[ADDR_W-1:26], instr[25:0]}, zero-extended if ADDR_W < 26... if ADDR_W <= 26 use instr[ADDR_W-1:0]. Then FETCH.
- MEM:
  - mem_req = 1, mem_addr = ALUOut[ADDR_W-1:0]; mem_we = 1 for sw with mem_wdata = B.
  - Wait for mem_ready. sw then goes to FETCH; lw latches MDR and goes to WB.
- WB:
  - Destination is rd for R-type, rt for addi/lw.
  - A write to r0 is discarded, and dbg_wb_en stays 0.
  - dbg_wb_en pulses for exactly this cycle. Then FETCH.
- Arithmetic is 32-bit wrap-around with no overflow trap. slt is signed.
- Register file: reads are combinational, writes are synchronous in WB, r0 always reads 0. With NREG < 32, register indices use the low log2(NREG) bits.
- Handshake rules:
  - mem_addr, mem_we and mem_wdata are stable while mem_req is high and not yet ready.
  - mem_req deasserts in the cycle after ready.
  - mem_ready with mem_req low is ignored.
- CPI: 3 (branch/jump), 4 (sw, R-type, addi), 5 (lw), plus memory wait cycles.
- TRAP: halted = 1, no further memory requests, no register writes. Only reset exits.
- Reset mid-request: mem_req drops immediately and no register or memory side effects occur.

Optional Feature:
MC_CPU_PERF_EN:
- Defined: adds output ports perf_cycles (32) and perf_instret (32).
  - perf_cycles counts every cycle that is neither in reset nor halted.
  - perf_instret increments when an instruction leaves its final state (WB, MEM for sw, or EXEC for branch/jump).
  - Both reset to 0 and wrap.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package mc_cpu_pkg holds:
  - state encoding;
  - opcode constants OP_RTYPE/OP_J/OP_BEQ/OP_BNE/OP_ADDI/OP_LW/OP_SW;
  - funct constants;
  - ALU op encoding, shared with alu_control.
- Sub-module mc_cpu_ctrl holds the FSM and decode, emitting mux selects and write enables. The datapath and register file stay in mc_cpu.

Test Plan:
- Reset with RESET_PC = 0x10, zero-wait memory -> first request addr 0x10; 4 fetches at 0x10..0x13 spaced by instruction CPI.
- addi r1, r0, 5; addi r2, r0, -3; add r3, r1, r2; slt r4, r2, r1 -> wb pulses r1 = 5, r2 = 0xFFFFFFFD, r3 = 2, r4 = 1.
- sw r3, 4(r0) then lw r5, 4(r0) with mem_ready delayed 3 cycles each -> write request addr 4, data 2, held stable 4 cycles; r5 = 2; lw takes 5 + 6 cycles.
- beq r1, r1, -1 at PC 0x20 -> next fetch addr 0x20; bne r1, r1, 8 -> next fetch PC + 1; j 0x40 -> fetch 0x40.
- addi r0, r0, 7 -> no dbg_wb_en pulse, r0 still reads 0; opcode 0x3F -> halted = 1 and mem_req stays 0 for 20 cycles.
- Assert rst_n low mid-lw wait -> mem_req falls asynchronously; after release, fetch restarts at RESET_PC and no register is written. With MC_CPU_PERF_EN defined, both counters read 0.

Source files
------------

// File: rtl/mc_cpu_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset core: FSM states, opcode/funct
// constants, ALU op encoding and the decode helpers used by the control unit.
package mc_cpu_pkg;

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb,
    StTrap
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    AluAdd,
    AluSub,
    AluAnd,
    AluOr,
    AluSlt
  } alu_op_e;

  // Non-R-type instructions all use the ALU as an adder (addi, lw/sw address).
  function automatic alu_op_e alu_control(logic [5:0] opcode, logic [5:0] funct);
    alu_op_e op;
    op = AluAdd;
    if (opcode == OP_RTYPE) begin
      case (funct)
        FN_SUB:  op = AluSub;
        FN_AND:  op = AluAnd;
        FN_OR:   op = AluOr;
        FN_SLT:  op = AluSlt;
        default: op = AluAdd;
      endcase
    end
    return op;
  endfunction

  function automatic logic is_legal(logic [5:0] opcode, logic [5:0] funct);
    case (opcode)
      OP_RTYPE: return funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
      OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_LW, OP_SW: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_cpu_ctrl.sv
// Control unit: multi-cycle FSM plus instruction decode, driving datapath selects and enables.
module mc_cpu_ctrl
  import mc_cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  input  logic       mem_ready_i,
  input  logic       a_eq_b_i,
  output state_e     state_o,
  output logic       mem_req_o,
  output logic       mem_we_o,
  output logic       addr_sel_alu_o,
  output logic       ir_we_o,
  output logic       ab_we_o,
  output logic       alu_we_o,
  output logic       alu_src_imm_o,
  output alu_op_e    alu_op_o,
  output logic       pc_branch_o,
  output logic       pc_jump_o,
  output logic       mdr_we_o,
  output logic       rf_we_o,
  output logic       dst_rt_o,
  output logic       wb_from_mdr_o,
  output logic       halted_o,
  output logic       instr_done_o
);

  state_e state_q, state_d;
  // Keeps mem_req low in the first cycle out of reset, since reset parks the FSM in fetch.
  logic   run_q;

  // State register and run flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFetch;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
    end
  end

  // Next-state and control outputs.
  always_comb begin
    state_d         = state_q;
    mem_req_o       = 1'b0;
    mem_we_o        = 1'b0;
    addr_sel_alu_o  = 1'b0;
    ir_we_o         = 1'b0;
    ab_we_o         = 1'b0;
    alu_we_o        = 1'b0;
    pc_branch_o     = 1'b0;
    pc_jump_o       = 1'b0;
    mdr_we_o        = 1'b0;
    rf_we_o         = 1'b0;
    halted_o        = 1'b0;
    instr_done_o    = 1'b0;
    alu_op_o        = alu_control(opcode_i, funct_i);
    alu_src_imm_o   = (opcode_i != OP_RTYPE);
    dst_rt_o        = (opcode_i != OP_RTYPE);
    wb_from_mdr_o   = (opcode_i == OP_LW);
    unique case (state_q)
      StFetch: begin
        mem_req_o = run_q;
        if (run_q && mem_ready_i) begin
          ir_we_o = 1'b1;
          state_d = StDecode;
        end
      end
      StDecode: begin
        ab_we_o = 1'b1;
        state_d = is_legal(opcode_i, funct_i) ? StExec : StTrap;
      end
      StExec: begin
        case (opcode_i)
          OP_BEQ, OP_BNE: begin
            pc_branch_o  = (opcode_i == OP_BEQ) ? a_eq_b_i : !a_eq_b_i;
            instr_done_o = 1'b1;
            state_d      = StFetch;
          end
          OP_J: begin
            pc_jump_o    = 1'b1;
            instr_done_o = 1'b1;
            state_d      = StFetch;
          end
          OP_LW, OP_SW: begin
            alu_we_o = 1'b1;
            state_d  = StMem;
          end
          default: begin
            alu_we_o = 1'b1;
            state_d  = StWb;
          end
        endcase
      end
      StMem: begin
        mem_req_o      = 1'b1;
        mem_we_o       = (opcode_i == OP_SW);
        addr_sel_alu_o = 1'b1;
        if (mem_ready_i) begin
          if (opcode_i == OP_SW) begin
            instr_done_o = 1'b1;
            state_d      = StFetch;
          end else begin
            mdr_we_o = 1'b1;
            state_d  = StWb;
          end
        end
      end
      StWb: begin
        rf_we_o      = 1'b1;
        instr_done_o = 1'b1;
        state_d      = StFetch;
      end
      StTrap: begin
        halted_o = 1'b1;
      end
      default: state_d = StFetch;
    endcase
  end

  assign state_o = state_q;

endmodule

// File: rtl/mc_cpu.sv
// Multi-cycle MIPS-subset core: datapath and register file around mc_cpu_ctrl.
// Optional feature macro: MC_CPU_PERF_EN adds perf_cycles / perf_instret counters.
module mc_cpu
  import mc_cpu_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       NREG     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              halted,
  output logic              dbg_wb_en,
  output logic [4:0]        dbg_wb_reg,
  output logic [31:0]       dbg_wb_data,
  output logic [ADDR_W-1:0] dbg_pc
`ifdef MC_CPU_PERF_EN
  ,
  output logic [31:0]       perf_cycles,
  output logic [31:0]       perf_instret
`endif
);

  localparam int unsigned RegIdxW = (NREG > 1) ? $clog2(NREG) : 1;

  logic [ADDR_W-1:0] pc_q, pc_d, target_q, target_d, jump_target;
  logic [31:0] ir_q, ir_d, a_q, a_d, b_q, b_d, alu_out_q, alu_out_d, mdr_q, mdr_d;
  logic [31:0] rf_q [NREG];
  logic [31:0] rf_d [NREG];

  state_e  state;
  alu_op_e alu_op;
  logic addr_sel_alu, ir_we, ab_we, alu_we, alu_src_imm, pc_branch, pc_jump;
  logic mdr_we, rf_we, dst_rt, wb_from_mdr, instr_done;

  logic [5:0]         opcode, funct;
  logic [4:0]         rs, rt, rd, dst;
  logic [RegIdxW-1:0] rs_idx, rt_idx, dst_idx;
  logic [31:0]        imm_sext, alu_b, alu_res, wb_data;

  assign opcode   = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign funct    = ir_q[5:0];
  assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};
  assign dst      = dst_rt ? rt : rd;
  assign rs_idx   = rs[RegIdxW-1:0];
  assign rt_idx   = rt[RegIdxW-1:0];
  assign dst_idx  = dst[RegIdxW-1:0];
  assign wb_data  = wb_from_mdr ? mdr_q : alu_out_q;

  logic unused_shamt;
  assign unused_shamt = ^ir_q[10:6];

  if (ADDR_W > 26) begin : g_jump_wide
    assign jump_target = {pc_q[ADDR_W-1:26], ir_q[25:0]};
  end else begin : g_jump_narrow
    assign jump_target = ir_q[ADDR_W-1:0];
  end

  mc_cpu_ctrl u_ctrl (
    .clk            (clk),
    .rst_n          (rst_n),
    .opcode_i       (opcode),
    .funct_i        (funct),
    .mem_ready_i    (mem_ready),
    .a_eq_b_i       (a_q == b_q),
    .state_o        (state),
    .mem_req_o      (mem_req),
    .mem_we_o       (mem_we),
    .addr_sel_alu_o (addr_sel_alu),
    .ir_we_o        (ir_we),
    .ab_we_o        (ab_we),
    .alu_we_o       (alu_we),
    .alu_src_imm_o  (alu_src_imm),
    .alu_op_o       (alu_op),
    .pc_branch_o    (pc_branch),
    .pc_jump_o      (pc_jump),
    .mdr_we_o       (mdr_we),
    .rf_we_o        (rf_we),
    .dst_rt_o       (dst_rt),
    .wb_from_mdr_o  (wb_from_mdr),
    .halted_o       (halted),
    .instr_done_o   (instr_done)
  );

  // Shared ALU.
  always_comb begin
    alu_b = alu_src_imm ? imm_sext : b_q;
    case (alu_op)
      AluSub:  alu_res = a_q - alu_b;
      AluAnd:  alu_res = a_q & alu_b;
      AluOr:   alu_res = a_q | alu_b;
      AluSlt:  alu_res = {31'b0, ($signed(a_q) < $signed(alu_b))};
      default: alu_res = a_q + alu_b;
    endcase
  end

  // Datapath next-state; branch target is formed from the already-incremented PC.
  always_comb begin
    pc_d = pc_q;
    if (ir_we) begin
      pc_d = pc_q + ADDR_W'(1);
    end else if (pc_branch) begin
      pc_d = target_q;
    end else if (pc_jump) begin
      pc_d = jump_target;
    end
    ir_d      = ir_we ? mem_rdata : ir_q;
    a_d       = ab_we ? rf_q[rs_idx] : a_q;
    b_d       = ab_we ? rf_q[rt_idx] : b_q;
    target_d  = ab_we ? pc_q + ADDR_W'(imm_sext) : target_q;
    alu_out_d = alu_we ? alu_res : alu_out_q;
    mdr_d     = mdr_we ? mem_rdata : mdr_q;
    rf_d      = rf_q;
    if (rf_we && (dst_idx != '0)) begin
      rf_d[dst_idx] = wb_data;
    end
  end

  // Datapath and register file state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      target_q  <= '0;
      alu_out_q <= '0;
      mdr_q     <= '0;
      rf_q      <= '{default: '0};
    end else begin
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      a_q       <= a_d;
      b_q       <= b_d;
      target_q  <= target_d;
      alu_out_q <= alu_out_d;
      mdr_q     <= mdr_d;
      rf_q      <= rf_d;
    end
  end

  assign mem_addr    = addr_sel_alu ? alu_out_q[ADDR_W-1:0] : pc_q;
  assign mem_wdata   = b_q;
  assign dbg_wb_en   = rf_we && (dst_idx != '0);
  assign dbg_wb_reg  = dst;
  assign dbg_wb_data = wb_data;
  // Outside fetch the PC has already advanced past the instruction in flight.
  assign dbg_pc      = (state == StFetch) ? pc_q : pc_q - ADDR_W'(1);

`ifdef MC_CPU_PERF_EN
  logic [31:0] perf_cycles_q, perf_cycles_d, perf_instret_q, perf_instret_d;

  // Performance counter next-state.
  always_comb begin
    perf_cycles_d  = halted ? perf_cycles_q : perf_cycles_q + 32'd1;
    perf_instret_d = instr_done ? perf_instret_q + 32'd1 : perf_instret_q;
  end

  // Performance counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cycles_q  <= '0;
      perf_instret_q <= '0;
    end else begin
      perf_cycles_q  <= perf_cycles_d;
      perf_instret_q <= perf_instret_d;
    end
  end

  assign perf_cycles  = perf_cycles_q;
  assign perf_instret = perf_instret_q;
`else
  logic unused_instr_done;
  assign unused_instr_done = instr_done;
`endif

endmodule

// File: tb/tb_mc_cpu.sv
// Self-checking bench for mc_cpu: behavioural memory with per-address wait states,
// scoreboards for fetch order/spacing and register writebacks.
module tb_mc_cpu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        halted, dbg_wb_en;
  logic [4:0]  dbg_wb_reg;
  logic [31:0] dbg_wb_data, dbg_pc;
`ifdef MC_CPU_PERF_EN
  logic [31:0] perf_cycles, perf_instret;
`endif

  mc_cpu #(
    .ADDR_W   (32),
    .RESET_PC (32'h10),
    .NREG     (32)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready),
    .halted      (halted),
    .dbg_wb_en   (dbg_wb_en),
    .dbg_wb_reg  (dbg_wb_reg),
    .dbg_wb_data (dbg_wb_data),
    .dbg_pc      (dbg_pc)
`ifdef MC_CPU_PERF_EN
    ,
    .perf_cycles (perf_cycles),
    .perf_instret(perf_instret)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  r;
    logic [31:0] d;
  } wb_t;
  typedef struct {
    logic [31:0] addr;
    int          gap;
  } fetch_t;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          last_fetch_cyc = 0;
  int          wr_cycles = 0;
  bit          fetch_chk = 1'b0;
  bit          patch_pending = 1'b0;
  logic [31:0] mem [256];
  wb_t         wb_q[$];
  fetch_t      fetch_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                                        logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                        logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] enc_j(logic [25:0] t);
    return {6'h02, t};
  endfunction

  // Data word 4 and the sw/lw instruction fetches get three wait states.
  function automatic int delay_for(logic [31:0] a);
    return (a == 32'h4 || a == 32'h14 || a == 32'h15) ? 3 : 0;
  endfunction

  task automatic push_wb(input logic [4:0] r, input logic [31:0] d);
    wb_t e;
    e.r = r;
    e.d = d;
    wb_q.push_back(e);
  endtask

  task automatic push_fetch(input logic [31:0] a, input int gap);
    fetch_t e;
    e.addr = a;
    e.gap  = gap;
    fetch_q.push_back(e);
  endtask

  task automatic load_program();
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h10] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);        // addi r1, r0, 5
    mem[8'h11] = enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD);     // addi r2, r0, -3
    mem[8'h12] = enc_r(5'd1, 5'd2, 5'd3, 6'h20);         // add  r3, r1, r2
    mem[8'h13] = enc_r(5'd2, 5'd1, 5'd4, 6'h2A);         // slt  r4, r2, r1
    mem[8'h14] = enc_i(6'h2B, 5'd0, 5'd3, 16'd4);        // sw   r3, 4(r0)
    mem[8'h15] = enc_i(6'h23, 5'd0, 5'd5, 16'd4);        // lw   r5, 4(r0)
    mem[8'h16] = enc_j(26'h20);                          // j    0x20
    mem[8'h20] = enc_i(6'h04, 5'd1, 5'd1, 16'hFFFF);     // beq  r1, r1, -1
    mem[8'h21] = enc_j(26'h40);                          // j    0x40
    mem[8'h40] = enc_i(6'h08, 5'd0, 5'd0, 16'd7);        // addi r0, r0, 7
    mem[8'h41] = enc_r(5'd0, 5'd1, 5'd6, 6'h20);         // add  r6, r0, r1
    mem[8'h42] = 32'hFC00_0000;                          // opcode 0x3F
    patch_pending = 1'b1;
  endtask

  // Cycle counter.
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory model; the beq at 0x20 is replaced by bne r1, r1, 8 after its first fetch.
  initial begin
    int wait_cnt;
    wait_cnt  = 0;
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && mem_req === 1'b1) begin
        if (wait_cnt >= delay_for(mem_addr)) begin
          mem_ready = 1'b1;
          wait_cnt  = 0;
          if (mem_we) begin
            check_eq("sw_addr", mem_addr, 32'h4);
            check_eq("sw_data", mem_wdata, 32'h2);
            check_eq("sw_req_cycles", wr_cycles + 1, 4);
            mem[mem_addr[7:0]] = mem_wdata;
            wr_cycles = 0;
          end else begin
            mem_rdata = mem[mem_addr[7:0]];
            if (mem_addr >= 32'h10) begin
              if (patch_pending && mem_addr == 32'h20) begin
                patch_pending = 1'b0;
                mem[8'h20] = enc_i(6'h05, 5'd1, 5'd1, 16'd8);
              end
              if (fetch_chk) begin
                if (fetch_q.size() == 0) begin
                  n_cmp++;
                  n_err++;
                  $display("FAIL fetch_extra: got fetch at %h, none expected", mem_addr);
                end else begin
                  fetch_t e;
                  e = fetch_q.pop_front();
                  check_eq("fetch_addr", mem_addr, e.addr);
                  if (e.gap >= 0) check_eq("fetch_gap", cyc - last_fetch_cyc, e.gap);
                end
              end
              last_fetch_cyc = cyc;
            end
          end
        end else begin
          mem_ready = 1'b0;
          wait_cnt++;
          if (mem_we) begin
            check_eq("sw_addr_hold", mem_addr, 32'h4);
            check_eq("sw_data_hold", mem_wdata, 32'h2);
            wr_cycles++;
          end
        end
      end else begin
        mem_ready = 1'b0;
        wait_cnt  = 0;
        wr_cycles = 0;
      end
    end
  end

  // Writeback scoreboard.
  initial forever begin
    @(negedge clk);
    if (dbg_wb_en === 1'b1) begin
      if (wb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL wb_extra: got r%0d = %h, none expected", dbg_wb_reg, dbg_wb_data);
      end else begin
        wb_t e;
        e = wb_q.pop_front();
        check_eq("wb_reg", {27'b0, dbg_wb_reg}, {27'b0, e.r});
        check_eq("wb_data", dbg_wb_data, e.d);
      end
    end
  end

  initial begin
    int  n_req;
    int  i;
    bit  found;
    rst_n = 1'b0;
    load_program();
    push_wb(5'd1, 32'd5);
    push_wb(5'd2, 32'hFFFF_FFFD);
    push_wb(5'd3, 32'd2);
    push_wb(5'd4, 32'd1);
    push_wb(5'd5, 32'd2);
    push_wb(5'd6, 32'd5);
    push_fetch(32'h10, -1);
    push_fetch(32'h11, 4);
    push_fetch(32'h12, 4);
    push_fetch(32'h13, 4);
    push_fetch(32'h14, 7);
    push_fetch(32'h15, 10);
    push_fetch(32'h16, 8);
    push_fetch(32'h20, 3);
    push_fetch(32'h20, 3);
    push_fetch(32'h21, 3);
    push_fetch(32'h40, 3);
    push_fetch(32'h41, 4);
    push_fetch(32'h42, 4);
    fetch_chk = 1'b1;

    repeat (2) @(negedge clk);
    check_eq("rst_mem_req", {31'b0, mem_req}, 32'd0);
    check_eq("rst_halted", {31'b0, halted}, 32'd0);
    check_eq("rst_wb_en", {31'b0, dbg_wb_en}, 32'd0);
    check_eq("rst_dbg_pc", dbg_pc, 32'h10);
    #1 rst_n = 1'b1;

    i = 0;
    while (halted !== 1'b1 && i < 3000) begin
      @(negedge clk);
      i++;
    end
    check_eq("halted", {31'b0, halted}, 32'd1);
    check_eq("halt_pc", dbg_pc, 32'h42);
    n_req = 0;
    repeat (20) begin
      @(negedge clk);
      if (mem_req !== 1'b0) n_req++;
    end
    check_eq("trap_req_cycles", n_req, 0);
    check_eq("fetch_q_left", fetch_q.size(), 0);
    check_eq("wb_q_left", wb_q.size(), 0);
    check_eq("mem4", mem[4], 32'd2);
`ifdef MC_CPU_PERF_EN
    check_eq("instret", perf_instret, 32'd12);
`endif

    // Second run: reset in the middle of the lw wait.
    fetch_chk = 1'b0;
    load_program();
    push_wb(5'd1, 32'd5);
    push_wb(5'd2, 32'hFFFF_FFFD);
    push_wb(5'd3, 32'd2);
    push_wb(5'd4, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("rst2_halted", {31'b0, halted}, 32'd0);
    #1 rst_n = 1'b1;

    found = 1'b0;
    i = 0;
    while (!found && i < 500) begin
      @(negedge clk);
      if (mem_req === 1'b1 && mem_we === 1'b0 && mem_addr == 32'h4) found = 1'b1;
      i++;
    end
    check_eq("lw_req_seen", {31'b0, found}, 32'd1);
    @(negedge clk);
    check_eq("lw_req_held", {31'b0, mem_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_req_drop", {31'b0, mem_req}, 32'd0);
    check_eq("rst_wb_en2", {31'b0, dbg_wb_en}, 32'd0);
    check_eq("wb_q_before_lw", wb_q.size(), 0);
`ifdef MC_CPU_PERF_EN
    check_eq("rst_perf_cycles", perf_cycles, 32'd0);
    check_eq("rst_perf_instret", perf_instret, 32'd0);
`endif
    push_wb(5'd1, 32'd5);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;

    found = 1'b0;
    i = 0;
    while (!found && i < 50) begin
      @(negedge clk);
      if (mem_req === 1'b1) found = 1'b1;
      i++;
    end
    check_eq("restart_req_seen", {31'b0, found}, 32'd1);
    check_eq("restart_addr", mem_addr, 32'h10);
    i = 0;
    while (wb_q.size() != 0 && i < 100) begin
      @(negedge clk);
      i++;
    end
    check_eq("post_reset_wb_left", wb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
